acc_dump_tx: RTL and testbench
==============================

// Module: acc_dump_tx
// PURPOSE
//  Reader side of the accumulator: snoops the ACC output bus and its WrAcc strobe.
//  On a rising edge of halt it snapshots the ACC value and the WrAcc write count.
//  It then streams them as a byte frame to the UART transmitter over a start/done handshake.
//  Sits between the CPU datapath and the UART TX in the debug path.
// PARAMETERS
//  DB      16     accumulator width in bits; NB=(DB+7)/8 ACC bytes sent (localparam)
//  CNT_W   16     WrAcc event counter width; must be a multiple of 8; NC=CNT_W/8 bytes sent
//  HEADER  8'hA5  first byte of every frame
// PORTS
//  clk        in   1      system clock; block samples on posedge (ACC updates on negedge)
//  reset      in   1      synchronous, active-high reset
//  acc_value  in   DB     accumulator output bus
//  wr_acc     in   1      accumulator write strobe (snooped)
//  halt       in   1      CPU halt level; a rising edge triggers one frame
//  tx_done    in   1      UART TX byte-complete pulse
//  tx_start   out  1      one-cycle pulse; request UART to send tx_data
//  tx_data    out  8      byte to send; stable from tx_start until tx_done
//  busy       out  1      high from trigger until frame_done inclusive
//  frame_done out  1      one-cycle pulse after the last byte's tx_done
// BEHAVIOUR
//  Reset values: tx_start=0, tx_data=0, busy=0, frame_done=0, write count=0, halt_q=0; FSM=IDLE.
//  Reset mid-frame: frame aborts immediately, with no further tx_start.
//  Counter: +1 on every posedge with wr_acc=1; saturates at all-ones; never wraps.
//  Counter is cleared only by reset. It keeps counting while a frame is in progress.
//  Edge detect: trig = halt & ~halt_q. halt_q is registered every cycle in every state.
//  FSM states:
//   IDLE   trig -> snapshot acc_value and count, idx=0, busy=1 -> SEND
//   SEND   tx_start=1 for 1 cycle, tx_data=byte[idx] -> WAIT
//   WAIT   tx_done=1: idx==LAST -> DONE, else idx++ -> SEND; otherwise hold
//   DONE   frame_done=1 for 1 cycle, busy=0 on exit -> IDLE
//  Latency: tx_start is high in the cycle after the cycle in which trig is seen.
//  tx_done is honoured only in WAIT, including the cycle right after SEND.
//  tx_done seen in IDLE, SEND or DONE is ignored.
//  Frame byte order: HEADER, ACC bytes MSB first, then count bytes MSB first.
//  ACC bytes: top byte zero-padded when DB%8 != 0. LAST = NB+NC (or NB+NC+1 with checksum).
//  halt edges while busy are ignored and are not queued.
//  A new frame requires halt to fall and rise again.
//  Snapshot is fixed at trigger; ACC/count changes during the frame do not alter sent bytes.
//  wr_acc and trig in the same cycle: the write is counted after the snapshot.
//  The snapshot therefore excludes it.
// CONFIGURATION
//  ACC_DUMP_CHECKSUM_EN defined:
//   one extra trailing byte = 8-bit sum mod 256 of all preceding frame bytes, header included.
//  ACC_DUMP_CHECKSUM_EN undefined:
//   frame ends after the count bytes; no sum logic is synthesised.
// STRUCTURE
//  Package acc_dump_pkg: FSM state enum (IDLE, SEND, WAIT, DONE), HEADER default, byte-index width.
//  Sub-module acc_wr_counter: saturating CNT_W counter with clk, reset, inc, count.
//  FSM, snapshot registers and byte mux stay in acc_dump_tx.
// TESTING (DB=16, CNT_W=16, UART model returns tx_done 3 cycles after tx_start)
//  1 Three wr_acc pulses, acc_value=16'h1234, halt rises:
//    bytes A5 12 34 00 03; frame_done pulses once; busy low after.
//  2 Same as test 1 with ACC_DUMP_CHECKSUM_EN:
//    bytes A5 12 34 00 03 EE.
//  3 acc_value changes to 16'hBEEF and 2 wr_acc pulses occur mid-frame:
//    sent bytes are unchanged; the next frame reports BE EF and count 00 05.
//  4 halt toggles low/high while busy:
//    no second frame; after frame_done, a fresh rising edge sends exactly one frame.
//  5 reset asserted during WAIT of byte 2:
//    tx_start, busy and frame_done are 0 next cycle; count=0; no stale bytes later.
//  6 0x10000 wr_acc pulses, then halt:
//    count bytes FF FF (saturated). Spurious tx_done in IDLE: no effect.

Source files
------------

// File: rtl/acc_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_dump_pkg
//  Description : Shared types and constants for the accumulator dump path.
//                Holds the frame FSM state encoding, the default frame header
//                byte and the width of the in-frame byte index.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_dump_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // First byte of every frame unless overridden by the top-level parameter
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Byte index width; frames of up to 256 bytes are addressable
    localparam int IDX_W = 8;

endpackage : acc_dump_pkg
`default_nettype wire

// File: rtl/acc_wr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : acc_wr_counter
//  Description : Saturating event counter for accumulator write strobes.
//                Increments once per clock while inc is high, sticks at
//                all-ones and is cleared only by reset.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                inc   - count enable (one event per cycle)
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_wr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule : acc_wr_counter
`default_nettype wire

// File: rtl/acc_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : acc_dump_tx
//  Description : Debug reader for the accumulator. Counts WrAcc strobes,
//                snapshots ACC and the count on a rising edge of halt and
//                streams them to a UART transmitter as one byte frame:
//                HEADER, ACC bytes (MSB first), count bytes (MSB first)
//                and, when ACC_DUMP_CHECKSUM_EN is defined, a trailing
//                mod-256 sum of all preceding frame bytes.
//  Config      : ACC_DUMP_CHECKSUM_EN - append checksum byte to each frame
//  Ports       : clk        - system clock (posedge)
//                reset      - synchronous active-high reset
//                acc_value  - accumulator output bus (DB bits)
//                wr_acc     - accumulator write strobe (snooped)
//                halt       - CPU halt level; rising edge starts a frame
//                tx_done    - UART byte-complete pulse
//                tx_start   - one-cycle request to send tx_data
//                tx_data    - byte being sent, stable until tx_done
//                busy       - frame in progress (through frame_done)
//                frame_done - one-cycle pulse after the last byte
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_dump_tx
    import acc_dump_pkg::*;
#(
    parameter int         DB     = 16,
    parameter int         CNT_W  = 16,   // must be a multiple of 8
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DB-1:0] acc_value,
    input  logic          wr_acc,
    input  logic          halt,
    input  logic          tx_done,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          busy,
    output logic          frame_done
);

    localparam int NB     = (DB + 7) / 8;
    localparam int NC     = CNT_W / 8;
    localparam int ACC_W  = 8 * NB;
    localparam int NDATA  = 1 + NB + NC;     // header + ACC + count bytes
`ifdef ACC_DUMP_CHECKSUM_EN
    localparam int NBYTES = NDATA + 1;
`else
    localparam int NBYTES = NDATA;
`endif
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_halt_q;
    logic                w_trig;
    logic [ACC_W-1:0]    r_acc_snap;
    logic [CNT_W-1:0]    r_cnt_snap;
    logic [CNT_W-1:0]    w_count;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_snap_en;
    logic [8*NDATA-1:0]  w_frame;
    logic [7:0]          w_tx_byte;

    // ------------------------------------------------------------------
    // WrAcc event counter; keeps running while a frame is in flight
    // ------------------------------------------------------------------
    acc_wr_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .count (w_count)
    );

    assign w_trig = halt & ~r_halt_q;

    // Frame image, byte 0 in the top lane
    assign w_frame = {HEADER, r_acc_snap, r_cnt_snap};

`ifdef ACC_DUMP_CHECKSUM_EN
    logic [7:0] w_sum;

    always_comb begin
        w_sum = 8'h00;
        for (int i = 0; i < NDATA; i++) begin
            w_sum = w_sum + w_frame[8*i +: 8];
        end
    end
`endif

    // Byte select by frame index
    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < NDATA; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_tx_byte = w_frame[8*(NDATA-i)-1 -: 8];
            end
        end
`ifdef ACC_DUMP_CHECKSUM_EN
        if (r_idx == IDX_W'(NDATA)) begin
            w_tx_byte = w_sum;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Frame sequencer: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_snap_en   = 1'b0;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        busy        = 1'b1;
        frame_done  = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_trig) begin
                    w_snap_en   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                tx_start    = 1'b1;
                tx_data     = w_tx_byte;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                tx_data = w_tx_byte;
                if (tx_done) begin
                    if (r_idx == LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = SEND;
                    end
                end
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, edge detect and snapshot registers. The snapshot takes the
    // counter value before this cycle's increment, so a strobe coincident
    // with the trigger lands in the next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_halt_q   <= 1'b0;
            r_idx      <= '0;
            r_acc_snap <= '0;
            r_cnt_snap <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_halt_q <= halt;
            r_idx    <= w_idx_nxt;
            if (w_snap_en) begin
                r_acc_snap <= ACC_W'(acc_value);
                r_cnt_snap <= w_count;
            end
        end
    end

endmodule : acc_dump_tx
`default_nettype wire

// File: tb/tb_acc_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_dump_tx
//  Description : Self-checking bench for acc_dump_tx (DB=16, CNT_W=16).
//                Expected frames are queued when halt is raised; a monitor
//                pops and compares every byte the DUT offers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_dump_tx;

    localparam int DB      = 16;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] acc_value;
    logic        wr_acc;
    logic        halt;
    logic        uart_done;
    logic        spur_done;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_done;

    assign tx_done = uart_done | spur_done;

    always #5 clk = ~clk;

    acc_dump_tx #(
        .DB     (DB),
        .CNT_W  (CNT_W),
        .HEADER (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_value  (acc_value),
        .wr_acc     (wr_acc),
        .halt       (halt),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         m_events  = 0;
    int         start_cnt = 0;
    int         fd_cnt    = 0;
    int         uart_tmr  = 0;
    logic [7:0] held      = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unbounded write-event count, saturated when reported
    always @(posedge clk) begin
        if (reset) m_events = 0;
        else if (wr_acc) m_events++;
    end

    function automatic int sat_cnt(input int ev);
        return (ev > CNT_MAX) ? CNT_MAX : ev;
    endfunction

    task automatic push_frame(input logic [15:0] acc, input int cnt);
        logic [15:0] c;
        logic [7:0]  b[5];
        int          sum;
        c   = cnt[15:0];
        b   = '{8'hA5, acc[15:8], acc[7:0], c[15:8], c[7:0]};
        sum = 0;
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            sum += int'(b[i]);
        end
`ifdef ACC_DUMP_CHECKSUM_EN
        exp_q.push_back(8'(sum));
`endif
    endtask

    // UART model: tx_done three cycles after each tx_start
    always @(negedge clk) begin
        uart_done = 1'b0;
        if (uart_tmr > 0) begin
            uart_tmr--;
            if (uart_tmr == 0) uart_done = 1'b1;
        end
        if (tx_start === 1'b1) uart_tmr = 3;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx_start: got byte %0h expected no byte at %0t", tx_data, $time);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
            held = tx_data;
        end else if (busy === 1'b1 && frame_done !== 1'b1) begin
            check("tx_data_hold", {24'h0, tx_data}, {24'h0, held});
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            check("busy_at_frame_done", {31'h0, busy}, 32'h1);
        end
    end

    // mode 0: quiet; 1: ACC/count change mid-frame; 2: halt toggles; 3: random
    task automatic run_frame(input logic wr_at_trig, input int mode);
        int fd0;
        bit seen;
        fd0 = fd_cnt;
        @(negedge clk);
        push_frame(acc_value, sat_cnt(m_events));
        halt   = 1'b1;
        wr_acc = wr_at_trig;
        @(negedge clk);
        halt   = 1'b0;
        wr_acc = 1'b0;
        check("start_latency", {31'h0, tx_start}, 32'h1);
        check("busy_after_trig", {31'h0, busy}, 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen   = 1'b1;
                wr_acc = 1'b0;
                halt   = 1'b0;
            end else begin
                case (mode)
                    1: begin
                        if (c == 1) acc_value = 16'hBEEF;
                        if (c == 2 || c == 5) wr_acc = 1'b1;
                        if (c == 3 || c == 6) wr_acc = 1'b0;
                    end
                    2: begin
                        if (c == 3 || c == 6) halt = 1'b1;
                        if (c == 4 || c == 8) halt = 1'b0;
                    end
                    3: begin
                        wr_acc    = 1'($urandom_range(0, 1));
                        acc_value = 16'($urandom);
                    end
                    default: ;
                endcase
            end
        end
        check("frame_done_seen", {31'h0, seen}, 32'h1);
        @(negedge clk);
        wr_acc = 1'b0;
        check("busy_after_frame", {31'h0, busy}, 32'h0);
        check("frame_done_pulse", {31'h0, frame_done}, 32'h0);
        check("frames_done_count", 32'(fd_cnt - fd0), 32'h1);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int base;
        int fd0;
        reset     = 1'b1;
        acc_value = 16'h0000;
        wr_acc    = 1'b0;
        halt      = 1'b0;
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'h0, tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Three writes, ACC=1234
        acc_value = 16'h1234;
        repeat (3) begin
            wr_acc = 1'b1;
            @(negedge clk);
            wr_acc = 1'b0;
            @(negedge clk);
        end
        run_frame(1'b0, 0);

        // Snapshot holds while ACC and count move; next frame sees them
        run_frame(1'b0, 1);
        run_frame(1'b0, 0);

        // halt re-edges while busy are dropped; fresh edge gives one frame
        run_frame(1'b0, 2);
        run_frame(1'b0, 0);

        // Write coincident with trigger is excluded from the snapshot
        run_frame(1'b1, 0);
        run_frame(1'b0, 0);

        // Randomized traffic
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                wr_acc    = 1'($urandom_range(0, 1));
                acc_value = 16'($urandom);
            end
            run_frame(1'($urandom_range(0, 1)), 3);
        end

        // Reset while waiting on the second byte
        fd0  = fd_cnt;
        base = start_cnt;
        @(negedge clk);
        push_frame(acc_value, sat_cnt(m_events));
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (start_cnt >= base + 2) break;
            @(negedge clk);
        end
        check("reset_reached_byte2", 32'(start_cnt - base), 32'h2);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_tx_start", {31'h0, tx_start}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_frame_done", {31'h0, frame_done}, 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_frame_done", 32'(fd_cnt - fd0), 32'h0);
        run_frame(1'b0, 0);

        // Saturation
        @(negedge clk);
        wr_acc = 1'b1;
        repeat (CNT_MAX + 5) @(negedge clk);
        wr_acc = 1'b0;

        // Spurious tx_done in IDLE
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("spur_no_start", {31'h0, tx_start}, 32'h0);
        check("spur_not_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        run_frame(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_acc_dump_tx
`default_nettype wire
